// File: rtl/module_booth_ctrl.sv
// Booth radix-2 multiplier sequencer: LOAD, then N rounds of EVAL/SHIFT, then a one-cycle DONE.
// add/sub are decoded from the live {q0,q_1}; every other output comes from registered state/count.
module module_booth_ctrl #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          q0,
    input  logic          q_1,
    output logic          load,
    output logic          add,
    output logic          sub,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD:    cnt <= CW'(N);
                // Guarded so the counter can never wrap below zero.
                SHIFT:   if (cnt != '0) cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = EVAL;
            EVAL:    state_nx = SHIFT;
            SHIFT:   state_nx = (cnt <= CW'(1)) ? DONE : EVAL;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        sub   = 1'b0;
        shift = 1'b0;
        done  = 1'b0;
        busy  = 1'b0;
        case (state)
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            EVAL: begin
                sub  = q0 & ~q_1;
                add  = ~q0 & q_1;
                busy = 1'b1;
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign count = cnt;

endmodule

// File: tb/tb_module_booth_ctrl.sv
// Bench for module_booth_ctrl: timeline reference model plus a behavioural Booth datapath.
`timescale 1ns/1ps
module tb_module_booth_ctrl;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          q0, q_1;
    logic          load, add, sub, shift, busy, done;
    logic [CW-1:0] count;

    module_booth_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .q0(q0), .q_1(q_1),
        .load(load), .add(add), .sub(sub), .shift(shift),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Behavioural Booth datapath driven by the controller outputs.
    logic [N-1:0] acc = '0, qreg = '0, mcand = '0;
    logic         qm1 = 1'b0;
    logic [N-1:0] mcand_in = '0, mplier_in = '0;
    assign q0  = qreg[0];
    assign q_1 = qm1;

    always @(posedge clk) begin
        if (load) begin
            acc   <= '0;
            qreg  <= mplier_in;
            qm1   <= 1'b0;
            mcand <= mcand_in;
        end else if (add)   acc <= acc + mcand;
        else if (sub)       acc <= acc - mcand;
        else if (shift)     {acc, qreg, qm1} <= {acc[N-1], acc, qreg};
    end

    // Reference: t = cycles since the accepted start's LOAD, -1 when idle.
    int               t = -1;
    logic [2*N-1:0]   exp_prod = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) t = -1;
        else if (t < 0) begin
            if (start) begin
                t = 0;
                exp_prod = {{N{mcand_in[N-1]}}, mcand_in} * {{N{mplier_in[N-1]}}, mplier_in};
            end
        end else if (t == 2*N + 1) t = -1;
        else t = t + 1;
    end

    logic [1:0] acts_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit ld, ev, sh, dn, bz;
        int c;
        logic [6+CW-1:0] exp_v;
        @(negedge clk);
        cyc++;
        ld = (t == 0);
        ev = (t >= 1) && (t <= 2*N) && (t % 2 == 1);
        sh = (t >= 2) && (t <= 2*N) && (t % 2 == 0);
        dn = (t == 2*N + 1);
        bz = (t >= 0);
        c  = (t >= 1) ? N - (t - 1) / 2 : 0;
        exp_v = {ld, ev & ~q0 & q_1, ev & q0 & ~q_1, sh, bz, dn, CW'(c)};
        check("controls", {load, add, sub, shift, busy, done, count}, exp_v);
        check("onehot", ($countones({load, add, sub, shift}) <= 1), 1);
        if (ev) acts_q.push_back({add, sub});
        if (done) done_cnt++;
        if (dn) check("product", {acc, qreg}, exp_prod);
    endtask

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] prod;
        logic [2*N-1:0] acts;   // per EVAL {add,sub}, first EVAL in bits [1:0]
    } vec_t;
    vec_t vecs[4];

    task automatic run_mult(input vec_t v, input bit inject);
        int n = 0;
        bit seen = 0;
        int d0 = done_cnt;
        mcand_in  = v.a;
        mplier_in = v.b;
        start = 1'b1;
        acts_q.delete();
        do begin
            step();
            n++;
            start = inject && (n == 2 || n == 5 || n == 2*N + 2);
            if (done) seen = 1;
        end while (!seen && n < 4*N + 10);
        check("done_latency", seen ? n : -1, 2*N + 2);
        check("eval_count", acts_q.size(), N);
        for (int i = 0; i < acts_q.size() && i < N; i++)
            check("eval_action", acts_q[i], v.acts[2*i +: 2]);
        check("table_product", {acc, qreg}, v.prod);
        step();
        start = 1'b0;
        step();
        step();
        check("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int first_done, second_load, d0;
        vecs[0] = '{a: 4'd5,    b: 4'b0011, prod: 8'h0F, acts: 8'b00_10_00_01};
        vecs[1] = '{a: 4'd3,    b: 4'b1000, prod: 8'hE8, acts: 8'b01_00_00_00};
        vecs[2] = '{a: 4'b1001, b: 4'b0111, prod: 8'hCF, acts: 8'b10_00_00_01};
        vecs[3] = '{a: 4'd7,    b: 4'b0101, prod: 8'h23, acts: 8'b10_01_10_01};

        #1 rst = 1'b0;
        #2 check("reset_outputs", {load, add, sub, shift, busy, done, count}, '0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();

        foreach (vecs[i]) run_mult(vecs[i], 1'b0);
        run_mult(vecs[0], 1'b1);
        run_mult(vecs[3], 1'b1);

        // Asynchronous reset during the first EVAL (which subtracts).
        mcand_in  = 4'd5;
        mplier_in = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("mid_sub_before_reset", sub, 1'b1);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1 check("mid_reset_async", {load, add, sub, shift, busy, done, count}, '0);
        step();
        step();
        rst = 1'b1;
        repeat (2*N + 4) step();
        check("no_done_after_abort", done_cnt - d0, 0);
        run_mult(vecs[1], 1'b0);

        // Start held high: second LOAD two cycles after the done cycle.
        first_done  = -1;
        second_load = -1;
        mcand_in  = 4'd6;
        mplier_in = 4'b1101;
        start = 1'b1;
        for (int i = 0; i < 3*N + 8; i++) begin
            step();
            if (done && first_done < 0) first_done = cyc;
            if (load && first_done >= 0 && second_load < 0) second_load = cyc;
        end
        start = 1'b0;
        check("held_reload_gap", second_load - first_done, 2);
        repeat (2*N + 4) step();

        // Randomised traffic against the reference timeline and product.
        for (int i = 0; i < 400; i++) begin
            if (t < 0) begin
                mcand_in  = N'($urandom);
                mplier_in = N'($urandom);
                if (mcand_in == {1'b1, {(N-1){1'b0}}}) mcand_in = '0;
            end
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        repeat (2*N + 4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/module_booth_ctrl.md
MODULE_BOOTH_CTRL -- requirements
Module: module_booth_ctrl

Interface
REQ-001 The block SHALL provide parameter N, default 4, setting the multiplier operand width (iterations per multiplication).
REQ-002 The block SHALL provide parameter CW, default $clog2(N+1), setting the iteration-counter width.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  multiplication request from the operand-load FSM.
REQ-006 q0  input  1  current multiplier LSB Q[0] from the Booth datapath.
REQ-007 q_1  input  1  Booth extension bit Q[-1] from the Booth datapath.
REQ-008 load  output  1  load A/B into the datapath and clear the accumulator and Q[-1].
REQ-009 add  output  1  accumulator <= accumulator + M.
REQ-010 sub  output  1  accumulator <= accumulator - M.
REQ-011 shift  output  1  arithmetic right shift of {accumulator, Q, Q[-1]}.
REQ-012 busy  output  1  multiplication in progress.
REQ-013 done  output  1  one-cycle pulse; the datapath product is valid in this cycle.
REQ-014 count  output  CW  remaining iterations.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD, EVAL, SHIFT, DONE.
REQ-016 IDLE: when start=1 at a clock edge, the next state SHALL be LOAD; otherwise the FSM SHALL remain in IDLE.
REQ-017 LOAD: load=1 for exactly one cycle, count SHALL be set to N, and the next state SHALL be EVAL.
REQ-018 EVAL, one cycle, then SHIFT:
- {q0,q_1}=10 -> sub=1
- {q0,q_1}=01 -> add=1
- {q0,q_1}=00 or 11 -> neither add nor sub
REQ-019 add and sub SHALL be a combinational decode of the state and {q0,q_1}; all other outputs SHALL be decoded from registered state/count only.
REQ-020 SHIFT: shift=1 and count SHALL decrement by 1; if count was 1, the next state SHALL be DONE, else EVAL.
REQ-021 DONE: done=1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 busy SHALL be 1 in LOAD, EVAL, SHIFT and DONE, and 0 in IDLE.
REQ-023 At most one of load, add, sub and shift SHALL be 1 in any cycle.
REQ-024 Latency: if start is sampled at edge k, done SHALL be high during the cycle after edge k+2N+1 (k+9 for N=4); total busy time SHALL be 2N+2 cycles.
REQ-025 start SHALL be ignored in every state except IDLE; a start pulse while busy SHALL be lost, not queued.
REQ-026 If start is held high continuously, a new LOAD SHALL occur exactly two cycles after the done cycle, with one IDLE cycle between them.
REQ-027 count SHALL never wrap below 0 and SHALL read 0 in DONE and IDLE.
REQ-028 Any unreachable state encoding SHALL transition to IDLE on the next edge, with all control outputs 0.

Reset
REQ-029 When rst=0, the FSM SHALL enter IDLE immediately, without waiting for a clock edge, and hold there while rst=0.
REQ-030 Reset values SHALL be load=add=sub=shift=busy=done=0 and count=0.
REQ-031 A reset asserted mid-operation SHALL abort the multiplication with no done pulse; the first start after reset release SHALL begin a fresh LOAD.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, using a reference Booth datapath model:
- Reset mid-operation: assert rst=0 during an EVAL with {q0,q_1}=10 -> sub, busy and count drop to 0 before the next edge; no done pulse follows.
- Basic product: N=4, A=5, B=4'b0011, start pulse -> EVAL actions sub, none, add, none; count steps 4,3,2,1,0; done at edge k+9; product 8'h0F.
- Negative multiplier: A=3, B=4'b1000 -> EVAL actions none, none, none, sub; product 8'hE8 (-24).
- Start held high: -> done, one IDLE cycle, then the second LOAD; no two controls are ever asserted together.
- Start ignored while busy: start pulses injected during EVAL, SHIFT and DONE -> the count sequence and done timing are unchanged; exactly one done per accepted start.
